muldiv_unit: RTL

Iterative RV32M/RV64M multiply-divide unit that sits beside the single-cycle ALU in the EX stage. It decodes the M-extension `funct3` the way the ALU control path decodes base ops, then computes the result over multiple cycles. A start/busy/done handshake lets the pipeline stall on it. It generalises the ALU operation path to parametrised width and adds multi-cycle sequencing, early-out special cases and pipeline flush.

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide beside the EX-stage ALU.
// Shift-add multiply and restoring divide, one bit per cycle, with early-outs.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] srcA_i,
   input  logic [XLEN-1:0] srcB_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              a_sgn, b_sgn;
   logic              is_div, is_rem;
   logic              a_neg, b_neg;
   logic              b_zero, ovf, early;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN-1:0]   early_res;

   // Operand decode at accept time
   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      unique case (funct3_i)
         F_MULH: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         F_MULHSU: a_sgn = 1'b1;
         F_DIV, F_REM: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         default: ;
      endcase
   end

   assign is_div = funct3_i[2];
   assign is_rem = funct3_i[2] & funct3_i[1];
   assign a_neg  = a_sgn & srcA_i[XLEN-1];
   assign b_neg  = b_sgn & srcB_i[XLEN-1];
   assign a_mag  = a_neg ? (~srcA_i + 1'b1) : srcA_i;
   assign b_mag  = b_neg ? (~srcB_i + 1'b1) : srcB_i;
   assign b_zero = (srcB_i == '0);
   assign ovf    = is_div & a_sgn & (srcA_i == MIN_INT) & (&srcB_i);
   assign early  = is_div & (b_zero | ovf);

   always_comb begin
      if (b_zero) begin
         early_res = is_rem ? srcA_i : '1;
      end else begin
         early_res = is_rem ? '0 : MIN_INT;
      end
   end

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] step;
   logic [2*XLEN-1:0] step_s;
   logic [XLEN-1:0]   rem_u;
   logic [XLEN-1:0]   rem_s;
   logic [XLEN-1:0]   fin_res;

   // Multiply: {acc, multiplier} shifts right. Divide: {rem, dividend} shifts left.
   assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]}
                   + (prod_q[0] ? {1'b0, b_q} : '0);
   assign rem_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
   assign div_ge   = (rem_sh >= {1'b0, b_q});
   assign div_diff = rem_sh[XLEN-1:0] - b_q;

   always_comb begin
      if (op_q[2]) begin
         step = {(div_ge ? div_diff : rem_sh[XLEN-1:0]),
                 prod_q[XLEN-2:0], div_ge};
      end else begin
         step = {mul_sum, prod_q[XLEN-1:1]};
      end
   end

   assign step_s = neg_q ? (~step + 1'b1) : step;
   assign rem_u  = step[2*XLEN-1:XLEN];
   assign rem_s  = neg_q ? (~rem_u + 1'b1) : rem_u;

   always_comb begin
      fin_res = step_s[XLEN-1:0];
      unique case (op_q)
         F_MUL:                     fin_res = step_s[XLEN-1:0];
         F_MULH, F_MULHSU, F_MULHU: fin_res = step_s[2*XLEN-1:XLEN];
         F_DIV, F_DIVU:             fin_res = step_s[XLEN-1:0];
         F_REM, F_REMU:             fin_res = rem_s;
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      b_d      = b_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  op_d   = funct3_i;
                  neg_d  = is_rem ? a_neg : (a_neg ^ b_neg);
                  cnt_d  = '0;
                  prod_d = {{XLEN{1'b0}}, a_mag};
                  b_d    = b_mag;
                  if (early) begin
                     state_d  = ST_DONE;
                     result_d = early_res;
                  end else begin
                     state_d = ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               prod_d = step;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d  = ST_DONE;
                  result_d = fin_res;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         prod_q   <= '0;
         b_q      <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         b_q      <= b_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = (state_q != ST_IDLE);
   assign done_o   = (state_q == ST_DONE);
   assign result_o = result_q;

endmodule
